// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use stall, branch flush,
// and a multi-cycle execute sequencer that holds the front of the pipe.
// Optional feature: define HAZARD_PERF_EN to add stall/flush perf counters.
module hazard_unit #(
    parameter int unsigned MC_LAT = 4
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [4:0]  ad1d,
    input  logic [4:0]  ad2d,
    input  logic [4:0]  ad1e,
    input  logic [4:0]  ad2e,
    input  logic [4:0]  rde,
    input  logic [1:0]  resltSrce,
    input  logic        pcSrce,
    input  logic        mcStarte,
    input  logic [4:0]  rdm,
    input  logic [4:0]  rdw,
    input  logic        regWrtm,
    input  logic        regWrtw,
    output logic        stallf,
    output logic        stalld,
    output logic        stalle,
    output logic        flushd,
    output logic        flushe,
    output logic        flushm,
    output logic [1:0]  fwdAe,
    output logic [1:0]  fwdBe,
    output logic        mcBusy,
    output logic        mcDone
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stallCnt,
    output logic [31:0] flushCnt
`endif
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_W   = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MC_LAT - 2);

    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               lw_stall_c;
    logic               mc_stall_c;

    // Memory stage wins over writeback: it holds the younger result.
    function automatic logic [FWD_W-1:0] fwd_sel(input logic [REG_W-1:0] src);
        logic [FWD_W-1:0] sel;
        sel = FWD_RF;
        if (regWrtm && (rdm != '0) && (rdm == src)) begin
            sel = FWD_MEM;
        end else if (regWrtw && (rdw != '0) && (rdw == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Forward selects and load-use detection; forwarding forced to the register file in reset.
    always_comb begin
        fwdAe      = FWD_RF;
        fwdBe      = FWD_RF;
        lw_stall_c = (resltSrce == RES_LOAD) && (rde != '0) &&
                     ((rde == ad1d) || (rde == ad2d));
        if (clr_n) begin
            fwdAe = fwd_sel(ad1e);
            fwdBe = fwd_sel(ad2e);
        end
    end

    // Multi-cycle sequencer state and occupancy counter.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: the start cycle counts as the first occupancy cycle, so load MC_LAT-2.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mcStarte) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Stall/flush outputs: multi-cycle stall masks branches and load-use; branch beats load-use.
    always_comb begin
        stallf     = 1'b0;
        stalld     = 1'b0;
        stalle     = 1'b0;
        flushd     = 1'b0;
        flushe     = 1'b0;
        flushm     = 1'b0;
        mcBusy     = 1'b0;
        mcDone     = 1'b0;
        mc_stall_c = 1'b0;
        if (!clr_n) begin
            flushd = 1'b1;
            flushe = 1'b1;
            flushm = 1'b1;
        end else begin
            mc_stall_c = ((state_q == ST_IDLE) && mcStarte) ||
                         ((state_q == ST_BUSY) && (cnt_q != '0));
            mcBusy     = (state_q == ST_BUSY);
            mcDone     = (state_q == ST_BUSY) && (cnt_q == '0);
            if (mc_stall_c) begin
                stallf = 1'b1;
                stalld = 1'b1;
                stalle = 1'b1;
                flushm = 1'b1;
            end else if (pcSrce) begin
                flushd = 1'b1;
                flushe = 1'b1;
            end else if (lw_stall_c) begin
                stallf = 1'b1;
                stalld = 1'b1;
                flushe = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    localparam int unsigned PERF_W = 32;

    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] flush_cnt_q;

    // Saturating perf counters; reset cycles never count since clr_n gates them.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stallf && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flushe && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stallCnt = stall_cnt_q;
    assign flushCnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (MC_LAT = 4).
module tb_hazard_unit;

    logic        clk;
    logic        clr_n;
    logic [4:0]  ad1d, ad2d, ad1e, ad2e, rde, rdm, rdw;
    logic [1:0]  resltSrce;
    logic        pcSrce, mcStarte, regWrtm, regWrtw;
    logic        stallf, stalld, stalle, flushd, flushe, flushm;
    logic [1:0]  fwdAe, fwdBe;
    logic        mcBusy, mcDone;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt, flushCnt;
`endif

    int unsigned n_checks;
    int unsigned n_pass;

    hazard_unit #(.MC_LAT(4)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .ad1d      (ad1d),
        .ad2d      (ad2d),
        .ad1e      (ad1e),
        .ad2e      (ad2e),
        .rde       (rde),
        .resltSrce (resltSrce),
        .pcSrce    (pcSrce),
        .mcStarte  (mcStarte),
        .rdm       (rdm),
        .rdw       (rdw),
        .regWrtm   (regWrtm),
        .regWrtw   (regWrtw),
        .stallf    (stallf),
        .stalld    (stalld),
        .stalle    (stalle),
        .flushd    (flushd),
        .flushe    (flushe),
        .flushm    (flushm),
        .fwdAe     (fwdAe),
        .fwdBe     (fwdBe),
        .mcBusy    (mcBusy),
        .mcDone    (mcDone)
`ifdef HAZARD_PERF_EN
        ,
        .stallCnt  (stallCnt),
        .flushCnt  (flushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ad1d = 0; ad2d = 0; ad1e = 0; ad2e = 0; rde = 0; rdm = 0; rdw = 0;
        resltSrce = 2'b00; pcSrce = 0; mcStarte = 0; regWrtm = 0; regWrtw = 0;
    endtask

    // Packs the stall/flush/mc flags: {stallf,stalld,stalle,flushd,flushe,flushm,mcBusy,mcDone}
    function automatic logic [31:0] flags();
        return 32'({stallf, stalld, stalle, flushd, flushe, flushm, mcBusy, mcDone});
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        clr_n = 1'b0;

        // Reset: forwarding would match but must read 00; flushes high, stalls low.
        regWrtm = 1; rdm = 5; ad1e = 5; mcStarte = 1;
        step(); step();
        #1;
        check("rst_flags", flags(), 32'b000_111_00);
        check("rst_fwdA",  32'(fwdAe), 32'd0);

        // Forwarding: memory beats writeback, then writeback alone.
        step();
        clr_n = 1'b1;
        idle_inputs();
        regWrtm = 1; rdm = 5; regWrtw = 1; rdw = 5; ad1e = 5; ad2e = 0;
        #1;
        check("fwd_memA",  32'(fwdAe), 32'd2);
        check("fwd_memB0", 32'(fwdBe), 32'd0);
        regWrtm = 0;
        #1;
        check("fwd_wbA",   32'(fwdAe), 32'd1);
        regWrtm = 1; rdm = 0; regWrtw = 0; ad2e = 0;
        #1;
        check("fwd_x0",    32'(fwdAe), 32'd0);
        regWrtm = 1; rdm = 9; ad2e = 9; regWrtw = 1; rdw = 9;
        #1;
        check("fwd_memB",  32'(fwdBe), 32'd2);

        // Load-use hazard on second decode source, then rd=x0, then branch priority.
        step();
        idle_inputs();
        resltSrce = 2'b01; rde = 7; ad2d = 7;
        #1;
        check("lw_stall",  flags(), 32'b110_010_00);
        rde = 0; ad2d = 0;
        #1;
        check("lw_x0",     flags(), 32'b000_000_00);
        rde = 7; ad1d = 7; pcSrce = 1;
        #1;
        check("br_over_lw", flags(), 32'b000_110_00);

        // Multi-cycle op: 3 stall cycles, done in cycle 4.
        step();
        idle_inputs();
        mcStarte = 1;
        #1;
        check("mc_c1", flags(), 32'b111_001_00);
        step();
        resltSrce = 2'b01; rde = 3; ad1d = 3;
        #1;
        check("mc_c2_lw_masked", flags(), 32'b111_001_10);
        step();
        resltSrce = 2'b00; rde = 0; ad1d = 0;
        pcSrce = 1;
        #1;
        check("mc_c3_br_ignored", flags(), 32'b111_001_10);
        step();
        #1;
        check("mc_c4_done_br", flags(), 32'b000_110_11);
        step();
        mcStarte = 0; pcSrce = 0;
        #1;
        check("mc_after", flags(), 32'b000_000_00);

        // Reset in the middle of a multi-cycle op aborts it with no done pulse.
        step();
        mcStarte = 1;
        step();
        mcStarte = 0;
        #1;
        check("abort_busy", 32'(mcBusy), 32'd1);
        step();
        clr_n = 1'b0;
        #1;
        check("abort_rst_flags", flags(), 32'b000_111_00);
        step();
        #1;
        check("abort_rst_hold", flags(), 32'b000_111_00);
        step();
        clr_n = 1'b1;
        #1;
        check("abort_idle", flags(), 32'b000_000_00);
        step();
        #1;
        check("abort_no_done", flags(), 32'b000_000_00);

`ifdef HAZARD_PERF_EN
        // Perf counters: 3 load-use cycles, then saturation from a preloaded max.
        check("perf_rst_stall", stallCnt, 32'd0);
        resltSrce = 2'b01; rde = 7; ad2d = 7;
        step(); step(); step();
        idle_inputs();
        #1;
        check("perf_stall3", stallCnt, 32'd3);
        check("perf_flush3", flushCnt, 32'd3);
        dut.stall_cnt_q = 32'hFFFF_FFFF;
        dut.flush_cnt_q = 32'hFFFF_FFFF;
        resltSrce = 2'b01; rde = 7; ad2d = 7;
        step();
        idle_inputs();
        #1;
        check("perf_stall_sat", stallCnt, 32'hFFFF_FFFF);
        check("perf_flush_sat", flushCnt, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The module SHALL have parameter MC_LAT, default 4, meaning execute-stage occupancy in cycles of a multi-cycle op; legal range 2..16.
REQ-002 The module SHALL have these ports, one per line (name direction width meaning):
  clk  in  1  single clock; all state updates on rising edge
  clr_n  in  1  reset; synchronous, active-low
  ad1d, ad2d  in  5  source register addresses in decode
  ad1e, ad2e, rde  in  5  source and destination register addresses in execute
  resltSrce  in  2  result source of execute instruction; 2'b01 = load
  pcSrce  in  1  branch taken or jump in execute
  mcStarte  in  1  execute instruction is a multi-cycle op
  rdm, rdw  in  5  destination addresses in memory and writeback
  regWrtm, regWrtw  in  1  register write enables in memory and writeback
  stallf, stalld, stalle  out  1  hold fetch PC, fetch/decode register, decode/execute register
  flushd, flushe, flushm  out  1  synchronous clear into the fetch/decode, decode/execute and execute/memory registers
  fwdAe, fwdBe  out  2  operand A/B forward select: 00 register file, 01 writeback, 10 memory
  mcBusy, mcDone  out  1  multi-cycle FSM busy; last occupancy cycle

Function
REQ-003 fwdAe SHALL be 10 if regWrtm and rdm!=0 and rdm==ad1e, else 01 if regWrtw and rdw!=0 and rdw==ad1e, else 00; fwdBe SHALL be identical using ad2e; both combinational.
REQ-004 lwStall SHALL be resltSrce==01 and rde!=0 and (rde==ad1d or rde==ad2d); combinational.
REQ-005 The FSM SHALL have states IDLE and BUSY with a 4-bit down-counter cnt.
REQ-006 In IDLE with mcStarte=1: stallf=stalld=stalle=flushm=1, next state BUSY, cnt<=MC_LAT-2.
REQ-007 In BUSY with cnt!=0: stallf=stalld=stalle=flushm=1, mcBusy=1, cnt decrements.
REQ-008 In BUSY with cnt==0: mcBusy=1, mcDone=1, no stall, next state IDLE.
REQ-009 A multi-cycle op SHALL therefore stall fetch/decode for exactly MC_LAT-1 cycles.
REQ-010 mcStarte SHALL be ignored in BUSY.
REQ-011 pcSrce SHALL be ignored while stalle=1.
REQ-012 pcSrce SHALL be honoured in IDLE and in the BUSY cnt==0 cycle.
REQ-013 Outside a multi-cycle stall, lwStall SHALL assert stallf=stalld=1 and flushe=1 for one cycle.
REQ-014 Outside a multi-cycle stall, pcSrce SHALL assert flushd=1 and flushe=1.
REQ-015 pcSrce SHALL take priority over lwStall: no stall, both flushes.
REQ-016 flushe SHALL be 0 whenever stalle=1.
REQ-017 flushm SHALL be 1 only during a multi-cycle stall or reset.
REQ-018 mcBusy SHALL be registered-state derived; all other outputs combinational.

Reset
REQ-019 When clr_n=0 at a rising edge, the FSM SHALL enter IDLE and cnt SHALL load 0.
REQ-020 While clr_n=0, flushd, flushe and flushm SHALL be 1.
REQ-021 While clr_n=0, stall outputs, mcBusy and mcDone SHALL be 0.
REQ-022 While clr_n=0, fwdAe and fwdBe SHALL be 00.
REQ-023 Reset asserted in BUSY SHALL abort the op with no mcDone pulse.

Configuration
REQ-024 With macro HAZARD_PERF_EN defined, the module SHALL add 32-bit outputs stallCnt and flushCnt.
REQ-025 stallCnt SHALL count cycles with stallf=1; flushCnt SHALL count cycles with flushe=1.
REQ-026 Both counters SHALL exclude reset cycles, reset to 0 and saturate at FFFFFFFF.
REQ-027 Without HAZARD_PERF_EN, the counter ports and logic SHALL be absent and all other behaviour unchanged.

Verification
REQ-028 regWrtm=1, rdm=5, regWrtw=1, rdw=5, ad1e=5, ad2e=0 -> fwdAe=10, fwdBe=00; then regWrtm=0 -> fwdAe=01.
REQ-029 resltSrce=01, rde=7, ad2d=7 -> one cycle stallf=stalld=flushe=1; with rde=0 -> no stall.
REQ-030 MC_LAT=4, mcStarte pulse held 4 cycles -> stalls high 3 cycles, mcDone high cycle 4, then IDLE.
REQ-031 pcSrce=1 during BUSY cnt=1 -> no flush; pcSrce=1 in cnt==0 cycle -> flushd=flushe=1.
REQ-032 clr_n=0 mid-BUSY -> next cycle IDLE, mcBusy=0, no mcDone, flushd=flushe=flushm=1 while low.
REQ-033 HAZARD_PERF_EN with lwStall forced 3 cycles -> stallCnt=3, flushCnt=3; preloaded FFFFFFFF stays saturated.
